ovf_guard_accum: RTL and testbench
==================================

OVF_GUARD_ACCUM -- requirements
Module: ovf_guard_accum

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4: accumulator and sample width in bits (unsigned, >=2).
REQ-002 The block SHALL have parameter CHANNELS, default 3: number of independent accumulators (>=1).
REQ-003 The block SHALL have parameter DEPTH, default 4: accepted samples per frame, counted over all channels (>=1).
REQ-004 The block SHALL define CW = max(1, clog2(CHANNELS)).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port in_valid, input, 1 bit: a sample is offered.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block can accept a sample.
REQ-009 The block SHALL have port in_ch, input, CW bits: target channel index.
REQ-010 The block SHALL have port in_data, input, WIDTH bits: sample value.
REQ-011 The block SHALL have port mode, input, 1 bit: 1 = saturate, 0 = wrap; sampled on the first accepted sample of a frame.
REQ-012 The block SHALL have port out_valid, output, 1 bit: frame result is available.
REQ-013 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-014 The block SHALL have port out_data, output, CHANNELS*WIDTH bits: channel k occupies bits [k*WIDTH +: WIDTH].
REQ-015 The block SHALL have port out_ovf, output, CHANNELS bits: sticky per-channel overflow for the frame.
REQ-016 The block SHALL have port out_err, output, 1 bit: sticky flag, set when a sample arrived with in_ch >= CHANNELS in the frame.
REQ-017 The block SHALL have port busy, output, 1 bit: high when the state is not IDLE.

Function
REQ-018 The FSM SHALL have exactly three states, IDLE, ACCUM and FLUSH, and SHALL decode every unused encoding to IDLE.
REQ-019 A sample SHALL be accepted exactly when in_valid && in_ready; in_ready SHALL be 1 in IDLE and ACCUM and 0 in FLUSH.
REQ-020 In IDLE, an accepted sample SHALL latch mode, update its channel, set count to 1 and go to ACCUM; with DEPTH=1 it SHALL go directly to FLUSH.
REQ-021 In ACCUM, each accepted sample SHALL increment count, and the DEPTH-th accepted sample SHALL cause a transition to FLUSH on the same edge.
REQ-022 out_valid SHALL be 1 only in FLUSH, asserted on the cycle after the DEPTH-th handshake, giving 1-cycle latency.
REQ-023 In FLUSH, out_data, out_ovf and out_err SHALL stay stable until out_valid && out_ready.
REQ-024 On the output handshake, all accumulators, flags and count SHALL clear to 0 and the FSM SHALL return to IDLE; no sample is accepted in that cycle.
REQ-025 Each add SHALL be computed at WIDTH+1 bits; a carry-out SHALL set out_ovf[ch] for the rest of the frame.
REQ-026 On carry, saturate mode SHALL store 2^WIDTH-1, and wrap mode SHALL store the low WIDTH bits.
REQ-027 When an accumulator is already at 2^WIDTH-1 in saturate mode, adding a nonzero sample SHALL hold the value and set out_ovf; adding 0 SHALL leave out_ovf unchanged.
REQ-028 A sample with in_ch >= CHANNELS SHALL be accepted and counted, SHALL modify no accumulator, and SHALL set out_err.
REQ-029 A change on the mode input mid-frame SHALL have no effect until the next frame.
REQ-030 Each channel SHALL have exactly one driver; accumulators SHALL update only in the clocked process, and all combinational logic SHALL assign every output on every path, with no latches.

Reset
REQ-031 With rst=1 at a clock edge, the FSM SHALL go to IDLE and count, all accumulators, out_ovf, out_err and the latched mode SHALL clear to 0.
REQ-032 After reset, out_valid=0, busy=0 and in_ready=1 SHALL hold on the following cycle.
REQ-033 rst SHALL take priority over any simultaneous input or output handshake, and the sample or result in that cycle SHALL be dropped.

Verification (WIDTH=4, CHANNELS=3, DEPTH=4)
REQ-034 Saturate test: mode=1, ch0 samples 9,9,0,0 -> out_valid 1 cycle after 4th; ch0=15, ovf=3'b001, err=0.
REQ-035 Wrap test: mode=0, ch1 samples 9,9, ch2 samples 3,4 -> ch1=2, ch2=7, ovf=3'b010.
REQ-036 Backpressure test: out_ready=0 for 5 cycles in FLUSH -> in_ready=0 and outputs unchanged; then out_ready=1 -> IDLE with zeros.
REQ-037 Mid-frame reset test: rst after 2 samples -> next cycle busy=0; the following 4-sample frame is unaffected by pre-reset data.
REQ-038 Bad channel test: in_ch=3 with data 5 among 4 samples -> err=1, no channel includes 5, and the frame completes after 4 handshakes.
REQ-039 Back-to-back test: out_ready held at 1 and in_valid held at 1 -> result handshake, then the next sample is accepted on the following cycle; mode toggled mid-frame has no effect.

Source files
------------

// File: rtl/ovf_guard_accum.sv
// Frame-based multi-channel accumulator with per-channel overflow detection.
// Each frame collects DEPTH samples across all channels, then holds the result until the consumer accepts it.
module ovf_guard_accum #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 3,
  parameter int DEPTH    = 4,
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CW-1:0]             in_ch,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       out_ovf,
  output logic                      out_err,
  output logic                      busy
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CW:0]      CH_LIM   = (CW + 1)'(CHANNELS);
  localparam logic [WIDTH-1:0] ACC_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_inc;
  logic               mode_q;
  logic               eff_mode;
  logic [WIDTH-1:0]   acc_q   [CHANNELS];
  logic [WIDTH-1:0]   acc_add [CHANNELS];
  logic [CHANNELS-1:0] carry;
  logic [CHANNELS-1:0] hit;
  logic [CHANNELS-1:0] ovf_q;
  logic               err_q;
  logic               in_idle;
  logic               accept;
  logic               out_fire;
  logic               ch_ok;
  logic               last;

  // Control: the unused encoding behaves exactly like IDLE so a corrupted state recovers on its own.
  always_comb begin
    // NOTE: every always_comb output is given a default before any branch so no path can infer a latch.
    state_d   = state_q;
    in_idle   = 1'b1;
    in_ready  = 1'b1;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      ACCUM: begin
        in_idle = 1'b0;
        busy    = 1'b1;
      end
      FLUSH: begin
        in_idle   = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase

    accept    = in_valid && in_ready;
    out_fire  = out_valid && out_ready;
    count_inc = in_idle ? CNT_W'(1) : count_q + CNT_W'(1);
    last      = (count_inc == DEPTH_C);

    if (out_fire) begin
      state_d = IDLE;
    end else if (accept) begin
      state_d = last ? FLUSH : ACCUM;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Datapath: the first sample of a frame uses the live mode input, later ones the latched copy.
  assign eff_mode = in_idle ? mode : mode_q;
  assign ch_ok    = ({1'b0, in_ch} < CH_LIM);

  always_comb begin
    logic [WIDTH:0] sum;
    sum = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      sum        = {1'b0, acc_q[k]} + {1'b0, in_data};
      carry[k]   = sum[WIDTH];
      acc_add[k] = (sum[WIDTH] && eff_mode) ? ACC_MAX : sum[WIDTH-1:0];
      hit[k]     = accept && ch_ok && (in_ch == CW'(k));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the accumulator array is a small register bank, so it is reset like any flop; a frame started after reset never sees stale sums.
      for (int k = 0; k < CHANNELS; k++) acc_q[k] <= '0;
      ovf_q   <= '0;
      err_q   <= 1'b0;
      count_q <= '0;
      mode_q  <= 1'b0;
    end else if (out_fire) begin
      for (int k = 0; k < CHANNELS; k++) acc_q[k] <= '0;
      ovf_q   <= '0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else if (accept) begin
      if (in_idle) mode_q <= mode;
      count_q <= count_inc;
      if (!ch_ok) err_q <= 1'b1;
      for (int k = 0; k < CHANNELS; k++) begin
        if (hit[k]) begin
          acc_q[k] <= acc_add[k];
          if (carry[k]) ovf_q[k] <= 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_pack
    assign out_data[g*WIDTH +: WIDTH] = acc_q[g];
  end

  assign out_ovf = ovf_q;
  assign out_err = err_q;

endmodule

// File: tb/tb_ovf_guard_accum.sv
// Self-checking bench: directed frames with literal expectations plus random traffic
// compared every cycle against a frame-level behavioural model.
module tb_ovf_guard_accum;

  localparam int WIDTH = 4;
  localparam int CH    = 3;
  localparam int DEPTH = 4;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [1:0]          in_ch;
  logic [WIDTH-1:0]    in_data;
  logic                mode;
  logic                out_valid;
  logic                out_ready;
  logic [CH*WIDTH-1:0] out_data;
  logic [CH-1:0]       out_ovf;
  logic                out_err;
  logic                busy;

  int n_checks = 0;
  int n_err    = 0;

  // Behavioural model: integer sums, a sample counter and a "result pending" flag.
  int        m_acc [CH];
  bit [CH-1:0] m_ovf;
  bit        m_err;
  bit        m_mode;
  bit        m_open;
  bit        m_pending;
  int        m_cnt;

  ovf_guard_accum #(.WIDTH(WIDTH), .CHANNELS(CH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_ch(in_ch), .in_data(in_data), .mode(mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf),
    .out_err(out_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < CH; k++) m_acc[k] = 0;
    m_ovf = '0; m_err = 0; m_open = 0; m_pending = 0; m_cnt = 0;
  endtask

  // Apply the rules for one rising edge, using the inputs currently driven.
  task automatic model_edge();
    int s;
    if (rst) begin
      model_clear();
      m_mode = 0;
    end else if (m_pending) begin
      if (out_ready) model_clear();
    end else if (in_valid) begin
      if (!m_open) m_mode = mode;
      m_open = 1;
      if (int'(in_ch) < CH) begin
        s = m_acc[in_ch] + int'(in_data);
        if (s > MAXV) begin
          m_ovf[in_ch] = 1'b1;
          s = m_mode ? MAXV : s - (MAXV + 1);
        end
        m_acc[in_ch] = s;
      end else begin
        m_err = 1;
      end
      m_cnt++;
      if (m_cnt == DEPTH) m_pending = 1;
    end
  endtask

  function automatic logic [CH*WIDTH-1:0] model_data();
    logic [CH*WIDTH-1:0] d = '0;
    for (int k = 0; k < CH; k++) d = d | (CH*WIDTH)'(m_acc[k] << (k * WIDTH));
    return d;
  endfunction

  task automatic compare_all();
    check("in_ready",  in_ready,  !m_pending);
    check("out_valid", out_valid, m_pending);
    check("busy",      busy,      m_open || m_pending);
    check("out_data",  out_data,  model_data());
    check("out_ovf",   out_ovf,   m_ovf);
    check("out_err",   out_err,   m_err);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic send(input logic [1:0] ch, input logic [WIDTH-1:0] d, input logic md);
    in_valid = 1'b1; in_ch = ch; in_data = d; mode = md;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_ch = '0; in_data = '0; mode = 1'b0; out_ready = 1'b1;
    model_clear(); m_mode = 0;
    step();
    rst = 1'b0;
    step();
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_out_valid", out_valid, 1'b0);

    // Saturate frame, held by backpressure.
    out_ready = 1'b0;
    send(2'd0, 4'd9, 1'b1);
    send(2'd0, 4'd9, 1'b1);
    send(2'd0, 4'd0, 1'b1);
    send(2'd0, 4'd0, 1'b1);
    check("sat_valid", out_valid, 1'b1);
    check("sat_data", out_data, 12'h00F);
    check("sat_ovf", out_ovf, 3'b001);
    check("sat_err", out_err, 1'b0);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("bp_in_ready", in_ready, 1'b0);
    check("bp_data", out_data, 12'h00F);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    check("bp_release_busy", busy, 1'b0);
    check("bp_release_data", out_data, 12'h000);

    // Wrap frame; mode toggled mid-frame must not matter.
    send(2'd1, 4'd9, 1'b0);
    send(2'd1, 4'd9, 1'b1);
    send(2'd2, 4'd3, 1'b1);
    send(2'd2, 4'd4, 1'b0);
    check("wrap_data", out_data, 12'h720);
    check("wrap_ovf", out_ovf, 3'b010);
    step();

    // Mid-frame reset.
    send(2'd0, 4'd7, 1'b0);
    send(2'd0, 4'd7, 1'b0);
    rst = 1'b1; in_valid = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    check("midrst_busy", busy, 1'b0);
    send(2'd0, 4'd1, 1'b0);
    send(2'd1, 4'd1, 1'b0);
    send(2'd2, 4'd1, 1'b0);
    send(2'd0, 4'd1, 1'b0);
    check("midrst_data", out_data, 12'h112);
    check("midrst_ovf", out_ovf, 3'b000);
    step();

    // Out-of-range channel.
    send(2'd0, 4'd1, 1'b0);
    send(2'd3, 4'd5, 1'b0);
    send(2'd1, 4'd2, 1'b0);
    send(2'd2, 4'd3, 1'b0);
    check("badch_valid", out_valid, 1'b1);
    check("badch_err", out_err, 1'b1);
    check("badch_data", out_data, 12'h321);
    step();

    // Back-to-back streaming with mode toggling every sample.
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_ch = 2'($urandom_range(0, 2)); in_data = 4'($urandom_range(0, 15)); mode = i[0];
      step();
    end
    in_valid = 1'b0;

    // Random traffic including occasional reset.
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 49) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_ch     = 2'($urandom_range(0, 3));
      in_data   = 4'($urandom_range(0, 15));
      mode      = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
